alarm_controller: RTL and testbench

Central sequencer of the home alarm: consumes decoded keypad commands and the two sensor lines, runs the arm/exit/entry/alarm state machine with tick-based delays, drives the siren, and publishes an 8-bit status word to the status link through a send/ack handshake. Sits inside the main module, between the keypad deserializer, the sensor pins and the status serializer.

---
 rtl/alarm_pkg.sv | 29 ++
 rtl/alarm_tick_gen.sv | 31 +++
 rtl/alarm_controller.sv | 156 +++++++++++++++
 tb/tb_alarm_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer: state encoding, keypad command codes
// and the layout of the published status word.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_e;

    localparam logic [3:0] CMD_ARM    = 4'hA;
    localparam logic [3:0] CMD_DISARM = 4'hD;
    localparam logic [3:0] CMD_PANIC  = 4'hF;

    localparam int STAT_Z1_BIT = 3;
    localparam int STAT_Z2_BIT = 4;

    function automatic logic [7:0] pack_status(state_e s, logic z1, logic z2);
        logic [7:0] st;
        st              = '0;
        st[2:0]         = s;
        st[STAT_Z1_BIT] = z1;
        st[STAT_Z2_BIT] = z2;
        return st;
    endfunction

endpackage

// File: rtl/alarm_tick_gen.sv
// Delay prescaler: one-cycle tick every TICK_DIV cycles, restarted by a synchronous clear.
module alarm_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: arm/exit/entry/alarm FSM with tick-based delays, siren drive and status handshake.
// Build macro ALARM_AUTO_REARM_EN: siren timeout returns to ARMED instead of DISARMED.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int EXIT_DLY   = 30,
    parameter int ENTRY_DLY  = 15,
    parameter int SIREN_TIME = 120
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SENSOR1_IN,
    input  logic       SENSOR2_IN,
    input  logic [3:0] KB_CMD,
    input  logic       KB_VALID,
    output logic       SIREN_OUT,
    output logic [7:0] STATUS_OUT,
    output logic       STATUS_SEND,
    input  logic       STATUS_ACK
);
    localparam int MAX_ED  = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
    localparam int MAX_DLY = (MAX_ED > SIREN_TIME) ? MAX_ED : SIREN_TIME;
    localparam int DLY_W   = $clog2(MAX_DLY + 1);

    state_e           state_q, state_d;
    logic             z1_q, z1_d, z2_q, z2_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [1:0]       s1_sync_q, s2_sync_q;
    logic [7:0]       stat_q, stat_now;
    logic             send_q;
    logic             tick, load, expire, zone1, zone2;
    logic             cmd_arm, cmd_disarm, cmd_panic;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_sync_q <= '0;
            s2_sync_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values; blocking here would collapse the synchronizer.
            s1_sync_q <= {s1_sync_q[0], SENSOR1_IN};
            s2_sync_q <= {s2_sync_q[0], SENSOR2_IN};
        end
    end

    assign zone1      = s1_sync_q[1];
    assign zone2      = s2_sync_q[1];
    assign cmd_arm    = KB_VALID && (KB_CMD == CMD_ARM);
    assign cmd_disarm = KB_VALID && (KB_CMD == CMD_DISARM);
    assign cmd_panic  = KB_VALID && (KB_CMD == CMD_PANIC);
    assign expire     = tick && (dly_q == DLY_W'(1));

    alarm_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk_i (CLK),
        .rst_i (RESET),
        .clr_i (load),
        .tick_o(tick)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        if (cmd_panic) begin
            state_d = ST_ALARM;
        end else if (cmd_disarm) begin
            state_d = ST_DISARMED;
        end else begin
            case (state_q)
                ST_DISARMED: if (cmd_arm) begin
                    state_d = ST_EXIT;
                    z1_d    = 1'b0;
                    z2_d    = 1'b0;
                end
                ST_EXIT: if (expire) state_d = ST_ARMED;
                ST_ARMED: begin
                    if (zone2) begin
                        state_d = ST_ALARM;
                        z2_d    = 1'b1;
                        z1_d    = z1_q | zone1;
                    end else if (zone1) begin
                        state_d = ST_ENTRY;
                        z1_d    = 1'b1;
                    end
                end
                ST_ENTRY: begin
                    if (zone2) begin
                        state_d = ST_ALARM;
                        z2_d    = 1'b1;
                    end else if (expire) begin
                        state_d = ST_ALARM;
                    end
                end
                ST_ALARM: if (expire) begin
`ifdef ALARM_AUTO_REARM_EN
                    state_d = ST_ARMED;
`else
                    state_d = ST_DISARMED;
`endif
                end
                default: ;
            endcase
        end

        // Every state entry (and a repeated PANIC) restarts the delay from its full length.
        load  = (state_d != state_q) || cmd_panic;
        dly_d = dly_q;
        if (load) begin
            case (state_d)
                ST_EXIT:  dly_d = DLY_W'(EXIT_DLY);
                ST_ENTRY: dly_d = DLY_W'(ENTRY_DLY);
                ST_ALARM: dly_d = DLY_W'(SIREN_TIME);
                default:  dly_d = '0;
            endcase
        end else if (tick && (dly_q != '0)) begin
            dly_d = dly_q - DLY_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_DISARMED;
            z1_q    <= 1'b0;
            z2_q    <= 1'b0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            dly_q   <= dly_d;
        end
    end

    // stat_q doubles as the last word sent: a new word goes out only when the live status differs.
    assign stat_now = pack_status(state_q, z1_q, z2_q);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_q <= '0;
            send_q <= 1'b0;
        end else if (send_q) begin
            if (STATUS_ACK) send_q <= 1'b0;
        end else if (stat_now != stat_q) begin
            stat_q <= stat_now;
            send_q <= 1'b1;
        end
    end

    assign SIREN_OUT   = (state_q == ST_ALARM);
    assign STATUS_OUT  = stat_q;
    assign STATUS_SEND = send_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: vector table plus hand sequences, status words
// checked against a scoreboard queue of expected words and arrival cycles.
module tb_alarm_controller;

    localparam logic [3:0] ARM    = 4'hA;
    localparam logic [3:0] DISARM = 4'hD;
    localparam logic [3:0] PANIC  = 4'hF;

`ifdef ALARM_AUTO_REARM_EN
    localparam logic       REARM     = 1'b1;
    localparam logic [7:0] W_END_Z1  = 8'h0A;
    localparam logic [7:0] W_END_Z12 = 8'h1A;
`else
    localparam logic       REARM     = 1'b0;
    localparam logic [7:0] W_END_Z1  = 8'h08;
    localparam logic [7:0] W_END_Z12 = 8'h18;
`endif

    typedef struct {
        logic [3:0] cmd;
        logic       kv;
        logic       s1;
        logic       s2;
        logic       push;
        logic [7:0] word;
        int         lat;
        int         wait_n;
        logic       siren;
    } vec_t;

    typedef struct {
        logic [7:0] word;
        int         due;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       SENSOR1_IN, SENSOR2_IN;
    logic [3:0] KB_CMD;
    logic       KB_VALID;
    logic       SIREN_OUT;
    logic [7:0] STATUS_OUT;
    logic       STATUS_SEND;
    logic       STATUS_ACK;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic       send_prev = 1'b0;
    logic       ack_prev  = 1'b0;
    logic       auto_ack  = 1'b1;
    logic [7:0] held = '0;
    exp_t       exp_q[$];
    vec_t       vecs[21];

    alarm_controller #(
        .TICK_DIV  (4),
        .EXIT_DLY  (3),
        .ENTRY_DLY (2),
        .SIREN_TIME(2)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SENSOR1_IN (SENSOR1_IN),
        .SENSOR2_IN (SENSOR2_IN),
        .KB_CMD     (KB_CMD),
        .KB_VALID   (KB_VALID),
        .SIREN_OUT  (SIREN_OUT),
        .STATUS_OUT (STATUS_OUT),
        .STATUS_SEND(STATUS_SEND),
        .STATUS_ACK (STATUS_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_word(input logic [7:0] word, input int due);
        exp_t e;
        e.word = word;
        e.due  = due;
        exp_q.push_back(e);
    endtask

    // One clock: sample after the edge, score the status handshake, then drive the ack.
    task automatic cycle();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        if (send_prev) begin
            if (ack_prev) begin
                check("send_drop_after_ack", STATUS_SEND, 1'b0);
            end else begin
                check("send_held", STATUS_SEND, 1'b1);
                check("status_frozen", STATUS_OUT, held);
            end
        end else if (STATUS_SEND) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %0h, expected none (cycle %0d)", STATUS_OUT, cyc);
            end else begin
                e = exp_q.pop_front();
                check("status_word", STATUS_OUT, e.word);
                if (e.due >= 0) check("status_cycle", cyc, e.due);
            end
            held = STATUS_OUT;
        end
        send_prev  = STATUS_SEND;
        STATUS_ACK = auto_ack && STATUS_SEND;
        ack_prev   = STATUS_ACK;
    endtask

    task automatic strobe(input logic [3:0] cmd);
        KB_CMD   = cmd;
        KB_VALID = 1'b1;
        cycle();
        KB_VALID = 1'b0;
    endtask

    function automatic vec_t mk(logic [3:0] cmd, logic kv, logic s1, logic s2, logic push,
                                logic [7:0] word, int lat, int wait_n, logic siren);
        vec_t v;
        v.cmd = cmd; v.kv = kv; v.s1 = s1; v.s2 = s2; v.push = push;
        v.word = word; v.lat = lat; v.wait_n = wait_n; v.siren = siren;
        return v;
    endfunction

    initial begin
        int c;

        vecs[0]  = mk(ARM,    1, 0, 0, 1,     8'h01,     2,  2,  0);
        vecs[1]  = mk(4'h0,   0, 0, 0, 1,     8'h02,     12, 14, 0);
        vecs[2]  = mk(4'h0,   0, 1, 0, 1,     8'h0B,     4,  4,  0);
        vecs[3]  = mk(4'h0,   0, 0, 0, 0,     8'h00,     0,  6,  0);
        vecs[4]  = mk(4'h0,   0, 0, 0, 1,     8'h0C,     2,  2,  1);
        vecs[5]  = mk(4'h0,   0, 0, 0, 0,     8'h00,     0,  6,  1);
        vecs[6]  = mk(4'h0,   0, 0, 0, 1,     W_END_Z1,  2,  2,  0);
        vecs[7]  = mk(DISARM, 1, 0, 0, REARM, 8'h08,     2,  4,  0);
        vecs[8]  = mk(ARM,    1, 0, 0, 1,     8'h01,     2,  2,  0);
        vecs[9]  = mk(4'h0,   0, 0, 0, 1,     8'h02,     12, 14, 0);
        vecs[10] = mk(4'h0,   0, 1, 1, 1,     8'h1C,     4,  4,  1);
        vecs[11] = mk(DISARM, 1, 0, 0, 1,     8'h18,     2,  4,  0);
        vecs[12] = mk(PANIC,  1, 0, 0, 1,     8'h1C,     2,  2,  1);
        vecs[13] = mk(PANIC,  1, 0, 0, 0,     8'h00,     0,  8,  1);
        vecs[14] = mk(4'h0,   0, 0, 0, 1,     W_END_Z12, 2,  2,  0);
        vecs[15] = mk(DISARM, 1, 0, 0, REARM, 8'h18,     2,  4,  0);
        vecs[16] = mk(ARM,    1, 0, 0, 1,     8'h01,     2,  2,  0);
        vecs[17] = mk(4'h0,   0, 0, 1, 0,     8'h00,     0,  5,  0);
        vecs[18] = mk(DISARM, 1, 0, 0, 1,     8'h00,     2,  2,  0);
        vecs[19] = mk(ARM,    1, 0, 0, 1,     8'h01,     2,  2,  0);
        vecs[20] = mk(4'h0,   0, 0, 0, 1,     8'h02,     12, 14, 0);

        RESET      = 1'b1;
        SENSOR1_IN = 1'b0;
        SENSOR2_IN = 1'b0;
        KB_CMD     = 4'h0;
        KB_VALID   = 1'b0;
        STATUS_ACK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_siren", SIREN_OUT, 1'b0);
        check("reset_status", STATUS_OUT, 8'h00);
        check("reset_send", STATUS_SEND, 1'b0);
        RESET = 1'b0;
        repeat (4) cycle();

        for (int i = 0; i < 21; i++) begin
            c          = cyc;
            KB_CMD     = vecs[i].cmd;
            KB_VALID   = vecs[i].kv;
            SENSOR1_IN = vecs[i].s1;
            SENSOR2_IN = vecs[i].s2;
            if (vecs[i].push) expect_word(vecs[i].word, c + vecs[i].lat);
            for (int k = 0; k < vecs[i].wait_n; k++) begin
                cycle();
                KB_VALID   = 1'b0;
                SENSOR1_IN = 1'b0;
                SENSOR2_IN = 1'b0;
            end
            check($sformatf("siren_vec%0d", i), SIREN_OUT, vecs[i].siren);
        end

        // ARMED: DISARM reaches the FSM on the same edge as a synchronized zone-1 event.
        c          = cyc;
        SENSOR1_IN = 1'b1;
        cycle();
        SENSOR1_IN = 1'b0;
        cycle();
        expect_word(8'h00, c + 4);
        strobe(DISARM);
        repeat (4) cycle();
        check("disarm_beats_sensor_siren", SIREN_OUT, 1'b0);

        // Unacknowledged word stays frozen across three state changes; only the latest follows.
        auto_ack = 1'b0;
        expect_word(8'h01, cyc + 2);
        strobe(ARM);
        cycle();
        strobe(DISARM);
        repeat (5) cycle();
        strobe(PANIC);
        repeat (2) cycle();
        check("coalesce_siren_on", SIREN_OUT, 1'b1);
        repeat (3) cycle();
        strobe(DISARM);
        repeat (7) cycle();
        check("coalesce_frozen_word", STATUS_OUT, 8'h01);
        check("coalesce_send_still_high", STATUS_SEND, 1'b1);
        expect_word(8'h00, -1);
        auto_ack = 1'b1;
        repeat (10) cycle();
        check("coalesce_single_word", exp_q.size(), 0);

        // Reset in the middle of a siren delay with a word still awaiting ack.
        auto_ack = 1'b0;
        expect_word(8'h01, cyc + 2);
        strobe(ARM);
        cycle();
        strobe(PANIC);
        repeat (2) cycle();
        check("pre_reset_siren", SIREN_OUT, 1'b1);
        check("pre_reset_send", STATUS_SEND, 1'b1);
        #3 RESET = 1'b1;
        #1;
        check("async_reset_siren", SIREN_OUT, 1'b0);
        check("async_reset_status", STATUS_OUT, 8'h00);
        check("async_reset_send", STATUS_SEND, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b0;
        send_prev  = 1'b0;
        ack_prev   = 1'b0;
        STATUS_ACK = 1'b0;
        auto_ack   = 1'b1;
        repeat (20) cycle();
        check("post_reset_no_word", STATUS_SEND, 1'b0);
        expect_word(8'h01, cyc + 2);
        strobe(ARM);
        repeat (3) cycle();
        expect_word(8'h00, cyc + 2);
        strobe(DISARM);
        repeat (4) cycle();

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
